// File: rtl/event_led_stretcher_if.sv
// Event/LED bundle between pulse-producing control logic and the LED stretcher.
// master drives events and observes status; slave is the stretcher itself.
interface event_led_stretcher_if #(
    parameter int unsigned MAX_PENDING = 15
) ();
    localparam int unsigned PW = $clog2(MAX_PENDING + 1);

    logic          pulse_in;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    modport master (
        output pulse_in,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/event_led_stretcher.sv
// Turns single-cycle event pulses into visible LED blinks, queueing events that
// arrive mid-blink (saturating at MAX_PENDING) and replaying them as extra blinks.
module event_led_stretcher #(
    parameter int unsigned ON_CYCLES   = 25_000_000,
    parameter int unsigned OFF_CYCLES  = 12_500_000,
    parameter int unsigned MAX_PENDING = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    event_led_stretcher_if.slave  bus
);
    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned PW      = $clog2(MAX_PENDING + 1);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t        state,    state_n;
    logic [CW-1:0] cnt,      cnt_n;
    logic [PW-1:0] pending,  pending_n;
    logic          led,      led_n;
    logic          busy,     busy_n;
    logic          overflow, overflow_n;

    logic accept;
    logic cnt_zero;
    logic start;

    // State and registered outputs; reset acts immediately, even mid-blink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pending  <= '0;
            led      <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pending  <= pending_n;
            led      <= led_n;
            busy     <= busy_n;
            overflow <= overflow_n;
        end
    end

    // Next-state, blink timing and pending-queue accounting.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pending_n  = pending;
        overflow_n = 1'b0;

        accept   = bus.pulse_in && (state != IDLE);
        cnt_zero = (cnt == '0);
        start    = (state == OFF) && cnt_zero && ((pending != '0) || bus.pulse_in);

        case (state)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end
            end
            ON: begin
                if (cnt_zero) begin
                    state_n = OFF;
                    cnt_n   = OFF_LOAD;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            OFF: begin
                if (start) begin
                    state_n = ON;
                    cnt_n   = ON_LOAD;
                end else if (cnt_zero) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A restart fed by the queue consumes one entry; one fed only by the
        // coincident pulse consumes that pulse directly.
        if (start) begin
            if (pending != '0) begin
                pending_n = pending + PW'(accept) - PW'(1);
            end else begin
                pending_n = '0;
            end
        end else if (accept) begin
            if (pending < PEND_MAX) begin
                pending_n = pending + PW'(1);
            end else begin
                overflow_n = 1'b1;
            end
        end

        led_n  = (state_n == ON);
        busy_n = (state_n != IDLE);
    end

    assign bus.led_out  = led;
    assign bus.busy     = busy;
    assign bus.pending  = pending;
    assign bus.overflow = overflow;

    ap_pending_bound: assert property (@(posedge clk) disable iff (reset) pending <= PEND_MAX);
    ap_led_implies_busy: assert property (@(posedge clk) disable iff (reset) led |-> busy);
    ap_idle_is_dark: assert property (@(posedge clk) disable iff (reset) (state == IDLE) |-> !led);

endmodule

// File: tb/tb_event_led_stretcher.sv
// Bench for event_led_stretcher: a cycle model pushes expected outputs into a
// scoreboard queue as each pulse is driven; the monitor pops and compares.
module tb_event_led_stretcher;
    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int MAXP = 3;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       led;
        logic       busy;
        logic       ovf;
        logic [1:0] pend;
    } obs_t;

    obs_t sbq[$];

    bit m_active;
    int m_pos;
    int m_q;
    bit m_ovf;
    int m_blinks;
    int m_ovfs;

    event_led_stretcher_if #(.MAX_PENDING(MAXP)) bus ();

    event_led_stretcher #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_pos    = 0;
        m_q      = 0;
        m_ovf    = 1'b0;
        m_blinks = 0;
        m_ovfs   = 0;
    endtask

    // Blink timeline: pos 0..ON-1 lit, ON..ON+OFF-1 dark gap.
    task automatic model_step(input bit p);
        obs_t e;
        bit   last;
        m_ovf = 1'b0;
        if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_blinks++;
            end
        end else begin
            last = (m_pos == ON + OFF - 1);
            if (last && (m_q > 0 || p)) begin
                m_q   = (m_q > 0) ? m_q + int'(p) - 1 : 0;
                m_pos = 0;
                m_blinks++;
            end else begin
                if (last) m_active = 1'b0;
                else      m_pos++;
                if (p) begin
                    if (m_q < MAXP) m_q++;
                    else begin
                        m_ovf = 1'b1;
                        m_ovfs++;
                    end
                end
            end
        end
        e.led  = m_active && (m_pos < ON);
        e.busy = m_active;
        e.ovf  = m_ovf;
        e.pend = 2'(m_q);
        sbq.push_back(e);
    endtask

    task automatic check_dark(input string name);
        check_val({name, " rst_led"},  32'(bus.led_out),  32'd0);
        check_val({name, " rst_busy"}, 32'(bus.busy),     32'd0);
        check_val({name, " rst_pend"}, 32'(bus.pending),  32'd0);
        check_val({name, " rst_ovf"},  32'(bus.overflow), 32'd0);
    endtask

    // Cycle c is the interval after the c-th clock edge following reset release.
    task automatic run_seq(input string name, input logic [63:0] pmask, input int ncyc,
                           input int reset_at, input int exp_blinks, input int exp_ovfs);
        int   blinks   = 0;
        int   ovfs     = 0;
        logic prev_led = 1'b0;
        bit   aborted  = 1'b0;
        obs_t e;
        bit   p;
        reset        = 1'b1;
        bus.pulse_in = 1'b0;
        model_reset();
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) begin
                e = sbq.pop_front();
                check_val($sformatf("%s c%0d led", name, c),  32'(bus.led_out),  32'(e.led));
                check_val($sformatf("%s c%0d busy", name, c), 32'(bus.busy),     32'(e.busy));
                check_val($sformatf("%s c%0d pend", name, c), 32'(bus.pending),  32'(e.pend));
                check_val($sformatf("%s c%0d ovf", name, c),  32'(bus.overflow), 32'(e.ovf));
                if (bus.led_out === 1'b1 && prev_led !== 1'b1) blinks++;
                prev_led = bus.led_out;
                if (bus.overflow === 1'b1) ovfs++;
            end
            if (c == reset_at) begin
                #1 reset = 1'b1;
                bus.pulse_in = 1'b0;
                #1;
                check_dark(name);
                aborted = 1'b1;
                break;
            end
            p = (c < 64) ? pmask[c] : 1'b0;
            bus.pulse_in = p;
            model_step(p);
            @(posedge clk);
            #1;
        end
        if (!aborted) begin
            check_val({name, " blinks"}, 32'(blinks), 32'((exp_blinks < 0) ? m_blinks : exp_blinks));
            check_val({name, " ovf_cnt"}, 32'(ovfs), 32'((exp_ovfs < 0) ? m_ovfs : exp_ovfs));
            check_val({name, " end_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        logic [63:0] m;
        reset        = 1'b0;
        bus.pulse_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_dark("t1");

        m = '0; m[10] = 1'b1;
        run_seq("t2", m, 20, -1, 1, 0);

        m = '0; m[10] = 1'b1; m[12] = 1'b1; m[13] = 1'b1;
        run_seq("t3", m, 32, -1, 3, 0);

        m = '0; m[14:10] = 5'h1f;
        run_seq("t4", m, 40, -1, 4, 1);

        m = '0; m[13:10] = 4'hf; m[16] = 1'b1;
        run_seq("t5", m, 45, -1, 5, 0);

        m = '0; m[12:10] = 3'h7;
        run_seq("t6a", m, 20, 13, 0, 0);
        m = '0; m[10] = 1'b1;
        run_seq("t6b", m, 20, -1, 1, 0);

        m = {$urandom, $urandom};
        run_seq("rnd_dense", m, 100, -1, -1, -1);
        m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        run_seq("rnd_sparse", m, 100, -1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
